switch_reader: RTL
==================

Name: switch_reader

Overview:
- Input-side counterpart of the board's LED/pattern output logic: reads raw board switch inputs (8 input switches, 4 mode selects, 4 config switches, concatenated) and turns them into clean, debounced state.
- Provides a 2-flop synchronizer and a per-bit debounce counter for each input.
- Outputs per-bit rise/fall pulses and a single-entry change-event register with a valid/ready handshake.
- Sits between the board switch pins and any consumer logic (pattern/mode control, config registers).

Parameters:
- WIDTH, 16: number of switch bits handled.
- DEBOUNCE_CYCLES, 1000: cycles a synchronized bit must differ from its stable value before the stable value flips. At 100 kHz this is 10 ms. Legal range 2..65535.
- CNT_W, 16: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- sw_in  in  WIDTH  raw asynchronous switch levels
- sw_stable  out  WIDTH  debounced switch state
- rise_pulse  out  WIDTH  one-cycle pulse per bit on a stable 0->1 flip
- fall_pulse  out  WIDTH  one-cycle pulse per bit on a stable 1->0 flip
- evt_valid  out  1  change event pending
- evt_ready  in  1  consumer accepts the event
- evt_data  out  WIDTH  sw_stable snapshot at the latest merged change
- evt_mask  out  WIDTH  bits that flipped since the last accepted event
- evt_coalesced  out  1  event holds more than one flip cycle

Behaviour:
- Reset (rst high at an edge): clears sync stages, sw_stable, all counters, rise/fall pulses, evt_valid, evt_data, evt_mask and evt_coalesced to 0. Reset mid-debounce or mid-handshake discards all in-progress state; no event is emitted for pre-reset activity.
- Synchronizer: sync1 <= sw_in; sync2 <= sync1. Only sync2 feeds the debounce logic.
- Per-bit debounce, evaluated every edge:
  - sync2[i] == sw_stable[i]: cnt[i] <= 0.
  - sync2[i] != sw_stable[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_stable[i] <= sync2[i]; cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - Any return to equality before the threshold restarts the count from 0. Glitches shorter than DEBOUNCE_CYCLES synchronized cycles never reach sw_stable.
- Latency: sw_in changes before edge k and stays stable -> sw_stable flips after edge k+1+DEBOUNCE_CYCLES.
- rise_pulse[i] / fall_pulse[i] are registered in the same edge as the flip: high exactly one cycle, aligned with the first cycle sw_stable shows the new value.
- flip_vec: the per-bit OR of rise_pulse and fall_pulse, sampled the cycle after the flip. Event logic acts on any cycle where flip_vec != 0. evt_valid rises one edge after the sw_stable flip, i.e. after edge k+2+DEBOUNCE_CYCLES.
- Event register, next-state rules:
  - accept = evt_valid & evt_ready.
  - flip_vec != 0 and (!evt_valid or accept): evt_valid <= 1; evt_mask <= flip_vec; evt_data <= sw_stable; evt_coalesced <= 0.
  - flip_vec != 0 and evt_valid and !evt_ready: evt_mask <= evt_mask | flip_vec; evt_data <= sw_stable; evt_coalesced <= 1. No event is ever lost; flips merge.
  - flip_vec == 0 and accept: evt_valid <= 0. mask, data and coalesced hold their values, but are don't-care while evt_valid is low.
  - Otherwise: hold.
- A bit flipping 0->1->0 while the event is stalled leaves its evt_mask bit set, with evt_data showing the final level.
- evt_data, evt_mask and evt_coalesced are stable while evt_valid=1 and evt_ready=0, except on a merge.
- A switch held high through reset release produces a normal rise after DEBOUNCE_CYCLES, followed by an event.
- Counters never wrap: the maximum value reached is DEBOUNCE_CYCLES-1.

Test Plan (all with DEBOUNCE_CYCLES=4, WIDTH=16):
- Clean edge: rst, then sw_in=0x0001 set before edge 0 -> sw_stable=0x0001 and rise_pulse=0x0001 for one cycle after edge 5; evt_valid=1, evt_data=0x0001, evt_mask=0x0001, evt_coalesced=0 after edge 6. With evt_ready=1 -> evt_valid=0 after edge 7.
- Glitch rejection: bit 3 high for 3 cycles then low -> sw_stable stays 0x0000, no pulses, evt_valid stays 0. A 4-cycle pulse -> rise, then a fall 4+ cycles after it returns low.
- Coalescing: evt_ready=0; bit 0 rises, later bit 8 rises -> single event with evt_mask=0x0101, evt_data=0x0101, evt_coalesced=1. Then evt_ready=1 for one cycle -> evt_valid drops.
- Simultaneous accept and new flip: event pending and evt_ready=1 in the same cycle that bit 2 flips -> evt_valid stays 1, evt_mask=0x0004 only, evt_coalesced=0.
- Reset mid-debounce: bit 5 high, rst asserted after 2 cycles of counting -> all outputs 0. The count restarts after reset; sw_stable[5]=1 at 1+4 edges after the first post-reset edge.
- Stalled bounce: evt_ready=0; bit 1 rises then later falls -> evt_mask=0x0002, evt_data[1]=0, evt_coalesced=1, and both rise_pulse and fall_pulse observed.

Source files
------------

// File: rtl/switch_reader.sv
// switch_reader: board switch input conditioning.
// Two-flop synchronizer, per-bit debounce counter, registered rise/fall
// pulses and a single-entry change-event register with valid/ready.
// Flips that arrive while an event is stalled are merged into it, so no
// change is ever dropped.

module switch_reader #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic [WIDTH-1:0] evt_mask,
  output logic             evt_coalesced
);

  // Terminal count: the flip happens on the edge where the counter already
  // holds this value, so the counter itself never exceeds it.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;

  logic [WIDTH-1:0] flip_vec;
  logic             accept;
  logic             evt_valid_nxt;
  logic [WIDTH-1:0] evt_data_nxt;
  logic [WIDTH-1:0] evt_mask_nxt;
  logic             evt_coalesced_nxt;

  // Bring raw switch levels into the clk domain; only sync2 is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: count consecutive cycles of disagreement, flip the
  // stable level at terminal count, restart on any agreement.
  always_comb begin
    stable_nxt = sw_stable;
    rise_nxt   = '0;
    fall_nxt   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != sw_stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nxt[i] = sync2[i];
          rise_nxt[i]   = sync2[i];
          fall_nxt[i]   = ~sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state and edge pulses; pulses line up with the first cycle
  // that sw_stable shows the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_stable  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sw_stable  <= stable_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign flip_vec = rise_pulse | fall_pulse;
  assign accept   = evt_valid & evt_ready;

  // Event next-state: open a fresh event when the slot is free or being
  // drained this cycle, otherwise merge into the stalled one.
  always_comb begin
    evt_valid_nxt     = evt_valid;
    evt_data_nxt      = evt_data;
    evt_mask_nxt      = evt_mask;
    evt_coalesced_nxt = evt_coalesced;
    if (flip_vec != '0) begin
      evt_valid_nxt = 1'b1;
      evt_data_nxt  = sw_stable;
      if (!evt_valid || accept) begin
        evt_mask_nxt      = flip_vec;
        evt_coalesced_nxt = 1'b0;
      end else begin
        evt_mask_nxt      = evt_mask | flip_vec;
        evt_coalesced_nxt = 1'b1;
      end
    end else if (accept) begin
      evt_valid_nxt = 1'b0;
    end
  end

  // Event register; mask/data/coalesced simply hold after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid     <= 1'b0;
      evt_data      <= '0;
      evt_mask      <= '0;
      evt_coalesced <= 1'b0;
    end else begin
      evt_valid     <= evt_valid_nxt;
      evt_data      <= evt_data_nxt;
      evt_mask      <= evt_mask_nxt;
      evt_coalesced <= evt_coalesced_nxt;
    end
  end

endmodule
